fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/riscv_pkg.sv | 8 +
 rtl/fetch_stage_if.sv | 14 +
 rtl/fetch_skid_buf.sv | 59 +++++
 rtl/fetch_stage.sv | 98 +++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end constants and the fetch FSM state type.
package riscv_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam int PC_STEP = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} fetch_state_t;
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory request/response bus between the fetch stage and imem.
interface fetch_stage_if
    import riscv_pkg::*;
#(
    parameter int WIDTH = XLEN
);
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_rvalid;
    logic [WIDTH-1:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_rvalid, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_rvalid, imem_rdata);
endinterface

// File: rtl/fetch_skid_buf.sv
// IF/ID output slot with a one-entry hold buffer for a response that lands
// while the slot is still occupied.
module fetch_skid_buf
    import riscv_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             stall,
    input  logic             push,
    input  logic [WIDTH-1:0] push_pc,
    input  logic [WIDTH-1:0] push_instr,
    output logic             consume,
    output logic             slot_free,
    output logic             if_valid,
    output logic [WIDTH-1:0] if_pc,
    output logic [WIDTH-1:0] if_instr
);
    logic             hold_valid;
    logic [WIDTH-1:0] hold_pc;
    logic [WIDTH-1:0] hold_instr;

    assign consume   = if_valid & ~stall;
    assign slot_free = ~if_valid | ~stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            if_valid   <= 1'b0;
            if_pc      <= '0;
            if_instr   <= WIDTH'(NOP_INSTR);
            hold_valid <= 1'b0;
            hold_pc    <= '0;
            hold_instr <= WIDTH'(NOP_INSTR);
        end else if (flush) begin
            if_valid   <= 1'b0;
            hold_valid <= 1'b0;
        end else if (push) begin
            if (slot_free) begin
                if_valid <= 1'b1;
                if_pc    <= push_pc;
                if_instr <= push_instr;
            end else begin
                hold_valid <= 1'b1;
                hold_pc    <= push_pc;
                hold_instr <= push_instr;
            end
        end else if (consume) begin
            // Refill from the hold buffer if it has something, else go empty.
            if_valid   <= hold_valid;
            hold_valid <= 1'b0;
            if (hold_valid) begin
                if_pc    <= hold_pc;
                if_instr <= hold_instr;
            end
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one-outstanding-request FSM and PC, feeding the IF/ID
// skid buffer.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int               WIDTH    = XLEN,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    fetch_stage_if.master    imem,
    output logic             if_valid,
    output logic [WIDTH-1:0] if_pc,
    output logic [WIDTH-1:0] if_instr
);
    fetch_state_t     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             kill_q, kill_d;
    logic             push, consume, slot_free;
    logic             req;
    logic [WIDTH-1:0] addr;

    assign imem.imem_req  = req;
    assign imem.imem_addr = addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        kill_d  = kill_q;
        push    = 1'b0;
        req     = 1'b0;
        addr    = '0;
        case (state_q)
            IDLE:  state_d = ISSUE;
            ISSUE: begin
                req     = 1'b1;
                addr    = pc_q;
                state_d = WAIT;
            end
            WAIT: if (imem.imem_rvalid) begin
                if (kill_q) begin
                    kill_d  = 1'b0;
                    state_d = ISSUE;
                end else begin
                    push    = 1'b1;
                    pc_d    = pc_q + WIDTH'(PC_STEP);
                    state_d = slot_free ? ISSUE : HOLD;
                end
            end
            HOLD:  if (consume) state_d = ISSUE;
            default: state_d = IDLE;
        endcase

        // A request already on the bus cannot be recalled, so it is marked
        // for discard instead.
        if (redirect) begin
            pc_d = redirect_pc & ~WIDTH'(3);
            push = 1'b0;
            if (state_q == ISSUE || (state_q == WAIT && !imem.imem_rvalid)) begin
                kill_d  = 1'b1;
                state_d = WAIT;
            end else begin
                kill_d  = 1'b0;
                state_d = ISSUE;
            end
        end
    end

    fetch_skid_buf #(.WIDTH(WIDTH)) u_skid (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect),
        .stall      (stall),
        .push       (push),
        .push_pc    (pc_q),
        .push_instr (imem.imem_rdata),
        .consume    (consume),
        .slot_free  (slot_free),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_instr   (if_instr)
    );
endmodule
